// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline control blocks.
// Contents: sequencer state encoding, register-field width, halt/NOP
// instruction words and the hard-wired zero register index.
package mips_pkg;

  localparam int unsigned REG_W = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } seqState_t;

  localparam logic [31:0]      HALT_INSTR = 32'h0000_0001;
  localparam logic [31:0]      NOP_INSTR  = 32'h0000_0000;
  localparam logic [REG_W-1:0] REG_ZERO   = '0;

endpackage

// File: rtl/hazard_compare.sv
// Read-after-write hazard detection for the ID stage (no forwarding).
// Ports:
//   id_rs, id_rt, id_uses_rt : sources read by the ID instruction
//   ex_/mem_/wb_ dst, wr     : destination and write flag per later stage
//   haz                      : ID instruction must wait
// WB_BYPASS=1 means the register file writes in the first half-cycle, so a
// WB-stage producer is already visible to ID and is ignored here.
module hazard_compare
  import mips_pkg::*;
#(
  parameter int unsigned WB_BYPASS = 0
) (
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  input  logic [REG_W-1:0] ex_dst,
  input  logic             ex_wr,
  input  logic [REG_W-1:0] mem_dst,
  input  logic             mem_wr,
  input  logic [REG_W-1:0] wb_dst,
  input  logic             wb_wr,
  output logic             haz
);

  // One producer stage against both ID sources; register 0 is never written.
  function automatic logic srcHit(input logic wr, input logic [REG_W-1:0] dst,
                                  input logic [REG_W-1:0] rs, input logic [REG_W-1:0] rt,
                                  input logic usesRt);
    return wr && (dst != REG_ZERO) && ((dst == rs) || (usesRt && (dst == rt)));
  endfunction

  logic wbHit;

  assign wbHit = (WB_BYPASS == 0) && srcHit(wb_wr, wb_dst, id_rs, id_rt, id_uses_rt);

  assign haz = srcHit(ex_wr, ex_dst, id_rs, id_rt, id_uses_rt)
            || srcHit(mem_wr, mem_dst, id_rs, id_rt, id_uses_rt)
            || wbHit;

endmodule

// File: rtl/pipeline_sequencer.sv
// Run/halt controller and hazard unit for the five-stage MIPS pipeline.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   start               : level request to run
//   if_halt             : IF holds the halt instruction
//   id_*, ex_*, mem_*, wb_* : hazard inputs (see hazard_compare)
//   ex_branch_taken     : branch in EX resolved taken
//   pc_en, pc_sel_branch, if_id_en, if_id_flush, id_ex_bubble, pipe_en :
//                         combinational per-stage controls
//   busy, done          : RUN/DRAIN and DONE indications
//   timeout, cycle_count, stall_count : registered run statistics
module pipeline_sequencer
  import mips_pkg::*;
#(
  parameter int unsigned CW           = 16,
  parameter int unsigned DRAIN_CYCLES = 4,
  parameter int unsigned MAX_CYCLES   = 1024,
  parameter int unsigned WB_BYPASS    = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             if_halt,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  input  logic [REG_W-1:0] ex_dst,
  input  logic [REG_W-1:0] mem_dst,
  input  logic [REG_W-1:0] wb_dst,
  input  logic             ex_wr,
  input  logic             mem_wr,
  input  logic             wb_wr,
  input  logic             ex_branch_taken,
  output logic             pc_en,
  output logic             pc_sel_branch,
  output logic             if_id_en,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             pipe_en,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic [CW-1:0]    cycle_count,
  output logic [CW-1:0]    stall_count
);

  localparam int unsigned  DW         = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [CW-1:0] CYC_LAST  = CW'(MAX_CYCLES - 1);
  localparam logic [DW-1:0] DRAIN_LOAD = DW'(DRAIN_CYCLES - 1);

  seqState_t     state, stateNext;
  logic [DW-1:0] drainCnt, drainNext;
  logic [CW-1:0] cycNext, stallNext;
  logic          toNext;
  logic          haz;

  hazard_compare #(.WB_BYPASS(WB_BYPASS)) uHaz (
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .id_uses_rt (id_uses_rt),
    .ex_dst     (ex_dst),
    .ex_wr      (ex_wr),
    .mem_dst    (mem_dst),
    .mem_wr     (mem_wr),
    .wb_dst     (wb_dst),
    .wb_wr      (wb_wr),
    .haz        (haz)
  );

  // State, drain counter and statistics registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      drainCnt    <= '0;
      cycle_count <= '0;
      stall_count <= '0;
      timeout     <= 1'b0;
    end else begin
      state       <= stateNext;
      drainCnt    <= drainNext;
      cycle_count <= cycNext;
      stall_count <= stallNext;
      timeout     <= toNext;
    end
  end

  // Next state, counter updates and per-stage controls.
  always_comb begin
    stateNext     = state;
    drainNext     = drainCnt;
    cycNext       = cycle_count;
    stallNext     = stall_count;
    toNext        = timeout;
    pc_en         = 1'b0;
    pc_sel_branch = 1'b0;
    if_id_en      = 1'b0;
    if_id_flush   = 1'b0;
    id_ex_bubble  = 1'b0;
    pipe_en       = 1'b0;
    busy          = 1'b0;
    done          = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          stateNext = RUN;
          cycNext   = '0;
          stallNext = '0;
          toNext    = 1'b0;
        end
      end

      RUN, DRAIN: begin
        busy     = 1'b1;
        pipe_en  = 1'b1;
        if_id_en = 1'b1;
        if (cycle_count != '1) cycNext = cycle_count + CW'(1);

        // A taken branch squashes everything younger, including a halt
        // fetched on the wrong path.
        if (ex_branch_taken) begin
          pc_en         = 1'b1;
          pc_sel_branch = 1'b1;
          if_id_flush   = 1'b1;
          id_ex_bubble  = 1'b1;
          stateNext     = RUN;
        end else if (state == DRAIN) begin
          if_id_flush  = 1'b1;
          id_ex_bubble = haz;
          if (drainCnt == '0) stateNext = DONE;
          else                drainNext = drainCnt - DW'(1);
        end else if (haz) begin
          // Hold PC and IF/ID (a pending halt stays in IF), bubble into EX.
          if_id_en     = 1'b0;
          id_ex_bubble = 1'b1;
          if (stall_count != '1) stallNext = stall_count + CW'(1);
        end else if (if_halt) begin
          if_id_flush = 1'b1;
          drainNext   = DRAIN_LOAD;
          stateNext   = DRAIN;
        end else begin
          pc_en = 1'b1;
        end

        // Watchdog wins over every other transition.
        if (cycle_count == CYC_LAST) begin
          stateNext = DONE;
          toNext    = 1'b1;
        end
      end

      DONE: begin
        done = 1'b1;
        if (!start) stateNext = IDLE;
      end

      default: stateNext = IDLE;
    endcase
  end

endmodule

// File: doc/pipeline_sequencer.md
Name: pipeline_sequencer

Overview:
- Run/halt controller and hazard unit for the five-stage MIPS pipeline (IF/ID/EX/MEM/WB).
- Starts execution on request and drives per-stage enable, flush and bubble signals.
- Stalls on read-after-write hazards, because the pipeline has no forwarding. Redirects the PC on taken branches.
- Detects the halt instruction (32'h0000_0001), drains the pipeline and reports completion, a watchdog timeout, cycle count and stall count.

Parameters:
- CW, 16, width of cycle_count and stall_count.
- DRAIN_CYCLES, 4, cycles spent in DRAIN after halt is accepted. Must be >= 1.
- MAX_CYCLES, 1024, watchdog limit in RUN+DRAIN cycles. Must be >= 2 and <= 2^CW.
- WB_BYPASS, 0, 1 = register file writes first half-cycle, so WB-stage destinations are ignored for hazards.

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  level request to begin execution
- if_halt  in  1  IF instruction equals 32'h0000_0001
- id_rs  in  5  ID source register rs
- id_rt  in  5  ID source register rt
- id_uses_rt  in  1  ID instruction reads rt (R-type, beq, sw)
- ex_dst / mem_dst / wb_dst  in  5 each  destination register in that stage
- ex_wr / mem_wr / wb_wr  in  1 each  that stage will write the register file
- ex_branch_taken  in  1  branch in EX resolved taken (zero && branch)
- pc_en  out  1  PC register load enable
- pc_sel_branch  out  1  PC takes branch target instead of PC+1
- if_id_en  out  1  IF/ID register load enable
- if_id_flush  out  1  IF/ID loads 32'h0 (NOP)
- id_ex_bubble  out  1  ID/EX control bits forced to 0
- pipe_en  out  1  EX/MEM and MEM/WB register enable
- busy  out  1  state is RUN or DRAIN
- done  out  1  state is DONE
- timeout  out  1  DONE was reached by watchdog
- cycle_count  out  CW  cycles spent in RUN+DRAIN
- stall_count  out  CW  cycles in which a hazard stall was applied

Behaviour:
- States: IDLE, RUN, DRAIN, DONE, held in a registered state.
- Reset:
  - state=IDLE.
  - All counters 0, timeout=0.
  - All outputs 0: pc_en=0, if_id_en=0, if_id_flush=0, id_ex_bubble=0, pipe_en=0, busy=0, done=0.
- Output timing:
  - Control outputs are combinational from state, registered counters and current inputs.
  - Counters and timeout are registered.
- IDLE:
  - All enables 0.
  - start=1 → RUN next cycle; cycle_count, stall_count and timeout are cleared on that edge.
- Hazard condition (haz): a stage's destination matches a source the ID instruction reads. Exact condition:
  - (ex_wr && ex_dst!=0 && (ex_dst==id_rs || (id_uses_rt && ex_dst==id_rt)))
  - OR the same condition for mem_dst/mem_wr
  - OR the same condition for wb_dst/wb_wr, included only when WB_BYPASS=0.
  - Register 0 never causes a hazard.
- RUN, priority order:
  1. ex_branch_taken: pc_en=1, pc_sel_branch=1, if_id_en=1, if_id_flush=1, id_ex_bubble=1, pipe_en=1. haz and if_halt are ignored this cycle.
  2. haz: pc_en=0, if_id_en=0, id_ex_bubble=1, pipe_en=1. stall_count increments (saturating at 2^CW-1). if_halt is ignored; the halt stays held in IF.
  3. if_halt: pc_en=0, if_id_en=1, if_id_flush=1, pipe_en=1. Load drain counter with DRAIN_CYCLES-1 → DRAIN.
  4. Otherwise: pc_en=1, if_id_en=1, pipe_en=1, all others 0.
- DRAIN:
  - Outputs: pc_en=0, if_id_en=1, if_id_flush=1, pipe_en=1.
  - id_ex_bubble=haz. No stall_count increment.
  - Drain counter decrements each cycle; at 0 → DONE.
  - ex_branch_taken has priority over the drain: the halt was on a wrong path. Outputs follow RUN rule 1 and the state returns to RUN.
- DONE:
  - done=1, all enables 0, counters frozen.
  - start=0 → IDLE, so a new run needs start to toggle.
- Watchdog:
  - cycle_count increments in every RUN/DRAIN cycle.
  - If cycle_count==MAX_CYCLES-1 at a clock edge in RUN/DRAIN: state → DONE, timeout ← 1. This overrides all other transitions.
- Asynchronous reset asserted mid-run: immediate return to IDLE with all outputs 0.

Decomposition:
- Shared package (mips_pkg): state encoding constants, HALT_INSTR=32'h0000_0001, NOP_INSTR=32'h0, register-0 constant.
- One natural sub-module: hazard_compare, the combinational haz evaluation with the WB_BYPASS parameter. It is reusable by a later forwarding unit.

Test Plan:
- Reset then start=1 with no hazards for 10 cycles → pc_en=1 from the first RUN cycle, busy=1, cycle_count=10, stall_count=0.
- Dependency in EX: ex_wr=1, ex_dst=5, id_rs=5, held 3 cycles (drops to MEM, then WB) → pc_en=0, id_ex_bubble=1 for 3 cycles, stall_count=3.
  - Same stimulus with WB_BYPASS=1 → 2 cycles.
- ex_dst=0, ex_wr=1, id_rs=0 → no stall.
  - id_rt=7 matching mem_dst=7 with id_uses_rt=0 → no stall.
- ex_branch_taken=1 together with haz=1 and if_halt=1 → pc_sel_branch=1, if_id_flush=1, state stays RUN, stall_count unchanged.
- if_halt=1 in RUN, DRAIN_CYCLES=4 → busy for 4 more cycles, then done=1, timeout=0.
  - Then start=0 → IDLE.
  - ex_branch_taken during the 2nd DRAIN cycle → back to RUN, pc_en=1.
- MAX_CYCLES=8, halt never seen → done=1, timeout=1 after 8 RUN cycles.
  - rst_n low while in DRAIN → all outputs 0 immediately.
